// File: rtl/div_seq_if.sv
// div_seq_if: start/busy/done handshake and operand/result bus for the sequential divider.
interface div_seq_if #(
    parameter int NW = 6,
    parameter int DW = 4
);
    logic          start;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          dbz;
    modport master(output start, dividend, divisor, input busy, done, quotient, remainder, dbz);
    modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, dbz);
endinterface

// File: rtl/div_seq.sv
// div_seq: unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module div_seq #(
    parameter int NW = 6,
    parameter int DW = 4
) (
    input logic       clk,
    input logic       rst_n,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(NW);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW:0]   r, r_n, r_sh, r_it;
    logic [NW-1:0] q, q_n, q_it, quo, quo_n;
    logic [DW-1:0] dsr, dsr_n, rem, rem_n;
    logic          dbz, dbz_n, ge;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            dsr   <= '0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            r     <= r_n;
            q     <= q_n;
            dsr   <= dsr_n;
            quo   <= quo_n;
            rem   <= rem_n;
            dbz   <= dbz_n;
        end
    end
    always_comb begin
        r_sh    = {r[DW-1:0], q[NW-1]};
        ge      = r_sh >= {1'b0, dsr};
        r_it    = ge ? r_sh - {1'b0, dsr} : r_sh;
        q_it    = {q[NW-2:0], ge};
        state_n = state;
        cnt_n   = cnt;
        r_n     = r;
        q_n     = q;
        dsr_n   = dsr;
        quo_n   = quo;
        rem_n   = rem;
        dbz_n   = dbz;
        if (bus.start && state != RUN) begin
            // a zero divisor skips the iterations and reports a saturated quotient
            if (bus.divisor == '0) begin
                state_n = DONE;
                quo_n   = '1;
                rem_n   = bus.dividend[DW-1:0];
                dbz_n   = 1'b1;
            end else begin
                state_n = RUN;
                cnt_n   = CW'(NW - 1);
                r_n     = '0;
                q_n     = bus.dividend;
                dsr_n   = bus.divisor;
                dbz_n   = 1'b0;
            end
        end else if (state == RUN) begin
            r_n   = r_it;
            q_n   = q_it;
            cnt_n = cnt - 1'b1;
            if (cnt == '0) begin
                state_n = DONE;
                quo_n   = q_it;
                rem_n   = r_it[DW-1:0];
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    assign bus.busy      = state == RUN;
    assign bus.done      = state == DONE;
    assign bus.quotient  = quo;
    assign bus.remainder = rem;
    assign bus.dbz       = dbz;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq; stimulus pushes expected results, a monitor checks each done pulse.
module tb_div_seq;
    localparam int NW = 6;
    localparam int DW = 4;
    typedef struct {
        int q;
        int r;
        int z;
        int issue;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   bcnt = 0;
    exp_t sb[$];
    exp_t m;
    div_seq_if #(.NW(NW), .DW(DW)) bus();
    div_seq #(.NW(NW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (!rst_n) bcnt = 0;
        else begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    m = sb.pop_front();
                    chk("quotient", int'(bus.quotient), m.q);
                    chk("remainder", int'(bus.remainder), m.r);
                    chk("dbz", int'(bus.dbz), m.z);
                    chk("latency", cyc - m.issue, m.z != 0 ? 1 : NW + 1);
                    chk("busy_cycles", bcnt, m.z != 0 ? 0 : NW);
                end
                bcnt = 0;
            end
        end
    end
    task automatic go(input int a, input int b, input int q, input int r, input int z, input bit push);
        bus.start    = 1'b1;
        bus.dividend = NW'(a);
        bus.divisor  = DW'(b);
        if (push) sb.push_back('{q, r, z, cyc});
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    task automatic wait_done();
        int k = 0;
        while (!bus.done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", int'(bus.done), 1);
        @(posedge clk);
        #1;
    endtask
    task automatic op(input int a, input int b, input int q, input int r, input int z);
        go(a, b, q, r, z, 1'b1);
        wait_done();
    endtask
    task automatic at(input int t);
        while (cyc < t) @(posedge clk);
        #1;
    endtask
    initial begin
        int v;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_quotient", int'(bus.quotient), 0);
        chk("rst_remainder", int'(bus.remainder), 0);
        chk("rst_dbz", int'(bus.dbz), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(45, 3, 15, 0, 0);
        op(44, 3, 14, 2, 0);
        op(63, 1, 63, 0, 0);
        op(0, 15, 0, 0, 0);
        op(10, 0, 63, 10, 1);
        op(9, 3, 3, 0, 0);
        // mid-RUN start ignored, then start held into the DONE cycle for a bubble-free restart
        v = cyc;
        go(40, 7, 5, 5, 0, 1'b1);
        at(v + 3);
        go(63, 1, 0, 0, 0, 1'b0);
        at(v + 5);
        bus.start    = 1'b1;
        bus.dividend = 6'd20;
        bus.divisor  = 4'd6;
        sb.push_back('{3, 2, 0, v + 7});
        at(v + 8);
        bus.start = 1'b0;
        wait_done();
        // reset aborts an operation in flight
        v = cyc;
        go(45, 3, 15, 0, 0, 1'b1);
        at(v + 4);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_quotient", int'(bus.quotient), 0);
        chk("abort_remainder", int'(bus.remainder), 0);
        chk("abort_dbz", int'(bus.dbz), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(bus.done), 0);
        end
        @(posedge clk);
        #1;
        op(33, 4, 8, 1, 0);
        for (int a = 0; a < 64; a++)
            for (int b = 1; b < 16; b++) op(a, b, a / b, a % b, 0);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
